// File: rtl/sadd_pkg.sv
// Shared definitions for the serial signed-add datapath: default widths,
// serializer state encoding and the operand sign-extension helper.
package sadd_pkg;

    localparam int N_LANES = 16;
    localparam int OP_W    = 8;
    localparam int ACC_W   = 32;
    localparam int IDX_W   = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Lossless widening of a two's-complement operand to accumulator width.
    function automatic logic [ACC_W-1:0] sext(input logic [OP_W-1:0] x);
        return {{(ACC_W-OP_W){x[OP_W-1]}}, x};
    endfunction

endpackage

// File: rtl/sadd_operand_serializer_lane_pick.sv
// Lowest-set-bit priority encoder over the remaining lane mask; only_one
// flags that the picked lane is the final one still pending.
module lane_pick #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          only_one
);

    // Scan from the top so the lowest set bit is the one that sticks.
    always_comb begin
        idx = {IW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx = mask[i] ? IW'(i) : idx;
        end
    end

    // Clearing the lowest set bit leaves nothing exactly when one bit was set.
    always_comb begin
        any      = |mask;
        only_one = any && ((mask & (mask - {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
    end

endmodule

// File: rtl/sadd_operand_serializer.sv
// Captures N signed operands plus an enable mask and streams the enabled
// lanes, sign-extended, one beat per cycle over a valid/ready interface.
module sadd_operand_serializer
    import sadd_pkg::*;
#(
    parameter int N  = N_LANES,
    parameter int W  = OP_W,
    parameter int DW = ACC_W,
    parameter int IW = IDX_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [N*W-1:0] lanes,
    input  logic [N-1:0]  lane_en,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last
);

    state_e         state_q, state_d;
    logic [N*W-1:0] hold_q, hold_d;
    logic [N-1:0]   mask_q, mask_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic [DW-1:0]  data_q, data_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           last_q, last_d;

    logic [IW-1:0]  pick_idx_s;
    logic           pick_any_s;
    logic           pick_one_s;
    logic [W-1:0]   pick_lane_s;
    logic [DW-1:0]  pick_data_s;

    // The mask excludes the lane already sitting in the output register,
    // so the encoder always names the next beat to present.
    lane_pick #(.N(N), .IW(IW)) u_pick (
        .mask     (mask_q),
        .idx      (pick_idx_s),
        .any      (pick_any_s),
        .only_one (pick_one_s)
    );

    assign pick_lane_s = hold_q[pick_idx_s*W +: W];

    generate
        if (W == OP_W && DW == ACC_W) begin : g_pkg_sext
            assign pick_data_s = pick_any_s ? sext(pick_lane_s) : {DW{1'b0}};
        end else begin : g_cast_sext
            assign pick_data_s = pick_any_s ? DW'($signed(pick_lane_s)) : {DW{1'b0}};
        end
    endgenerate

    // Next-state, capture and output-register loading.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    hold_d  = lanes;
                    mask_d  = lane_en;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (!valid_q || out_ready) begin
                    if (valid_q && last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        data_d  = {DW{1'b0}};
                        idx_d   = {IW{1'b0}};
                        last_d  = 1'b0;
                    end else begin
                        // An empty mask still yields one zero terminator beat.
                        valid_d = 1'b1;
                        data_d  = pick_data_s;
                        idx_d   = pick_idx_s;
                        last_d  = !pick_any_s || pick_one_s;
                        mask_d  = mask_q & ~({{(N-1){1'b0}}, 1'b1} << pick_idx_s);
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = {N{1'b0}};
                valid_d = 1'b0;
                data_d  = {DW{1'b0}};
                idx_d   = {IW{1'b0}};
                last_d  = 1'b0;
            end
        endcase
        busy_d = (state_d == SEND);
    end

    // State and output registers; reset discards any in-flight vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= {(N*W){1'b0}};
            mask_q  <= {N{1'b0}};
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= {DW{1'b0}};
            idx_q   <= {IW{1'b0}};
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_sadd_operand_serializer.sv
// Scoreboard bench: a queue-based reference model of the enabled-lane stream,
// checked by a negedge monitor against every transferred beat.
module tb_sadd_operand_serializer;

    localparam int N  = 16;
    localparam int W  = 8;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int BUDGET = 2000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load = 1'b0;
    logic           out_ready = 1'b0;
    logic [N*W-1:0] lanes = '0;
    logic [N-1:0]   lane_en = '0;
    logic           busy, out_valid, out_last;
    logic [DW-1:0]  out_data;
    logic [IW-1:0]  out_idx;

    always #5 clk = ~clk;

    sadd_operand_serializer #(.N(N), .W(W), .DW(DW), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .lanes     (lanes),
        .lane_en   (lane_en),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t  exp_q[$];
    int     errors = 0;
    int     checks = 0;
    bit     model_busy = 1'b0;
    int     lat_cnt = 0;
    int     beats_seen = 0;
    longint sum_seen = 0;
    bit     seen_idx10 = 1'b0;
    bit     stall_prev = 1'b0;
    beat_t  stall_beat;
    int     ready_mode = 0;
    int     pat_ph = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream readiness: always, 1-0-0 pattern, or random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (pat_ph == 0);
                pat_ph = (pat_ph + 1) % 3;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor plus reference model; state here describes the coming clock edge.
    always @(negedge clk) begin
        beat_t b, e;
        bit    xfer_last;
        int    cnt, k, v;
        if (!rst) begin
            exp_q.delete();
            model_busy = 1'b0;
            lat_cnt    = 0;
            stall_prev = 1'b0;
        end else begin
            xfer_last = 1'b0;
            b = '{out_data, out_idx, out_last};
            if (stall_prev) begin
                check("stall_valid_held", 64'(out_valid), 64'd1);
                check("stall_beat_held", 64'(b), 64'(stall_beat));
            end
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) check("first_beat_latency", 64'(out_valid), 64'd1);
            end
            if (out_valid) begin
                check("valid_only_when_vector_pending", 64'(model_busy), 64'd1);
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: got idx=%0d data=%0h expected no beat", out_idx, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'(b), 64'(e));
                        xfer_last = e.last;
                    end
                    beats_seen++;
                    sum_seen += longint'($signed(out_data));
                    if (out_idx == 4'd10) seen_idx10 = 1'b1;
                end
                stall_prev = !out_ready;
                stall_beat = b;
            end else begin
                stall_prev = 1'b0;
            end
            if (!model_busy && load) begin
                cnt = 0;
                k   = 0;
                for (int i = 0; i < N; i++) if (lane_en[i]) cnt++;
                if (cnt == 0) begin
                    exp_q.push_back('{{DW{1'b0}}, {IW{1'b0}}, 1'b1});
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (lane_en[i]) begin
                            k++;
                            v = $signed(lanes[i*W +: W]);
                            exp_q.push_back('{DW'(v), IW'(i), (k == cnt)});
                        end
                    end
                end
                model_busy = 1'b1;
                lat_cnt    = 2;
            end
            if (xfer_last) model_busy = 1'b0;
        end
    end

    function automatic logic [N*W-1:0] rnd_lanes();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_load(input logic [N*W-1:0] l, input logic [N-1:0] e);
        @(posedge clk);
        #1;
        lanes   = l;
        lane_en = e;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load    = 1'b0;
        lanes   = rnd_lanes();
        lane_en = N'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((model_busy || exp_q.size() != 0) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= BUDGET) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles expected under %0d", name, n, BUDGET);
        end
    endtask

    task automatic wait_model_free(input string name);
        int n = 0;
        while (model_busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= BUDGET) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles expected under %0d", name, n, BUDGET);
        end
    endtask

    initial begin
        logic [N*W-1:0] l;
        logic [N-1:0]   c_en;
        int             pc;

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_idx", 64'(out_idx), 64'd0);
        check("reset_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // All lanes, values 1..16, full throughput.
        ready_mode = 0;
        for (int i = 0; i < N; i++) l[i*W +: W] = W'(i + 1);
        beats_seen = 0;
        sum_seen   = 0;
        do_load(l, 16'hFFFF);
        wait_idle("all_lanes");
        check("all_lanes_beats", 64'(beats_seen), 64'd16);
        check("all_lanes_sum", 64'(sum_seen), 64'd136);

        // Lane 10 masked, extreme values at both ends.
        l = rnd_lanes();
        l[0 +: W]    = 8'h80;
        l[15*W +: W] = 8'h7F;
        beats_seen = 0;
        seen_idx10 = 1'b0;
        do_load(l, 16'hFBFF);
        wait_idle("lane10_off");
        check("lane10_off_beats", 64'(beats_seen), 64'd15);
        check("lane10_never_seen", 64'(seen_idx10), 64'd0);

        // Backpressure 1,0,0 pattern.
        ready_mode = 1;
        beats_seen = 0;
        do_load(rnd_lanes(), 16'hFFFF);
        wait_idle("backpressure");
        check("backpressure_beats", 64'(beats_seen), 64'd16);

        // Empty mask gives one terminator beat.
        ready_mode = 0;
        beats_seen = 0;
        do_load(rnd_lanes(), 16'h0000);
        wait_idle("empty_mask");
        check("empty_mask_beats", 64'(beats_seen), 64'd1);
        @(negedge clk);
        check("empty_mask_busy_clear", 64'(busy), 64'd0);

        // Load while busy is ignored; next load in the idle cycle is taken.
        ready_mode = 1;
        beats_seen = 0;
        do_load(rnd_lanes(), 16'hFFFF);
        repeat (4) @(posedge clk);
        do_load(rnd_lanes(), 16'h00F0);
        wait_model_free("first_vector");
        c_en = 16'h8421;
        do_load(rnd_lanes(), c_en);
        check("back_to_back_busy", 64'(busy), 64'd1);
        wait_idle("second_vector");
        check("ignored_load_beats", 64'(beats_seen), 64'd20);

        // Random vectors, random readiness, back to back.
        ready_mode = 2;
        for (int t = 0; t < 8; t++) begin
            wait_model_free("random_gap");
            c_en = N'($urandom);
            if (t == 3) c_en = '0;
            do_load(rnd_lanes(), c_en);
        end
        wait_idle("random");

        // Reset mid-stream after lane 5 transfers.
        ready_mode = 0;
        beats_seen = 0;
        do_load(rnd_lanes(), 16'hFFFF);
        pc = 0;
        while (beats_seen < 6 && pc < BUDGET) begin
            @(negedge clk);
            pc++;
        end
        check("reach_beat5", 64'(beats_seen), 64'd6);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_valid", 64'(out_valid), 64'd0);
        check("midreset_data", 64'(out_data), 64'd0);
        check("midreset_idx", 64'(out_idx), 64'd0);
        check("midreset_last", 64'(out_last), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_quiet", 64'(out_valid), 64'd0);
        end
        beats_seen = 0;
        do_load(rnd_lanes(), 16'h0101);
        wait_idle("after_reset");
        check("after_reset_beats", 64'(beats_seen), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sadd_operand_serializer.md
Name: sadd_operand_serializer

Overview:
- Transmit side of the serial signed-add datapath: captures a parallel vector of N signed W-bit operands, then emits the enabled lanes one per beat, sign-extended to DW bits.
- Uses a valid/ready stream that feeds a single shared SADD/SREG accumulator instead of an N-deep adder chain.
- A per-lane enable mask lets a generated circuit drop individual operands from the reduction.

Parameters:
- N, 16, number of operand lanes
- W, 8, operand width in bits (signed)
- DW, 32, output word width; must satisfy DW >= W
- IW, 4, lane-index width; must satisfy 2^IW >= N

Ports:
- clk       input   1       rising-edge clock
- rst       input   1       asynchronous, active-low reset; single clock domain
- load      input   1       request to capture lanes and lane_en
- lanes     input   N*W     packed operands; lane i = lanes[i*W +: W], two's complement
- lane_en   input   N       lane i is sent only if lane_en[i] = 1
- busy      output  1       a captured vector is still being sent
- out_valid output  1       out_data, out_idx and out_last are valid
- out_ready input   1       downstream accepts the beat
- out_data  output  DW      sign-extended operand
- out_idx   output  IW      lane number of the current beat
- out_last  output  1       final beat of this vector

Behaviour:
- Reset (async assert, sync release): busy=0, out_valid=0, out_data=0, out_idx=0, out_last=0; captured vector and remaining mask cleared.
- Reset may assert mid-stream. The in-flight vector is discarded and no further beats are emitted.
- FSM states: IDLE, SEND.
  - IDLE: busy=0, out_valid=0.
  - load=1 in IDLE captures lanes into a holding register and lane_en into the remaining mask, then moves to SEND.
- load while busy=1 is ignored: no capture, no state change.
- Latency: load accepted at edge t gives the first beat with out_valid=1 from edge t+1.
- SEND presents the lowest-indexed set bit of the remaining mask:
  - out_data = that lane sign-extended to DW bits.
  - out_idx = that lane number.
  - out_last = 1 when no other bit remains set.
- Handshake: a beat transfers on a cycle with out_valid & out_ready.
  - On transfer, clear that lane's bit and advance to the next set bit on the following cycle (one beat per cycle under full throughput).
  - While out_valid & !out_ready, out_data, out_idx and out_last hold stable. out_valid never drops without a transfer.
- The transfer with out_last=1 returns the FSM to IDLE. busy=0 and out_valid=0 on the next cycle.
  - A load in that IDLE cycle is accepted, so the gap between vectors is exactly one idle cycle.
- Empty mask (lane_en all 0 at capture): emits exactly one beat with out_data=0, out_idx=0, out_last=1. The downstream accumulator therefore always sees a terminator.
- Lanes and lane_en inputs may change freely after capture; only the registered copies are used.
- Arithmetic: pure sign extension {(DW-W){x[W-1]}, x}; no saturation or wrap, since widening is lossless.

Decomposition:
- Shared package (sadd_pkg):
  - Defaults N_LANES=16, OP_W=8, ACC_W=32, IDX_W=4.
  - State enum {IDLE, SEND}.
  - Sign-extension function sext(x) used here and by the matching accumulator.
- One sub-module, lane_pick:
  - Combinational lowest-set-bit priority encoder over an N-bit mask.
  - Outputs idx[IW-1:0], any, and only_one (drives out_last).

Test Plan:
- All 16 lanes enabled, lanes = 1,2,...,16, out_ready held 1 -> 16 consecutive beats idx 0..15, data 0x00000001..0x00000010, out_last only on idx 15; downstream sum = 136.
- lane_en = 16'hFBFF (lane 10 off), lane 0 = 8'h80, lane 15 = 8'h7F -> 15 beats; idx 10 never appears; first data 0xFFFFFF80, last data 0x0000007F with out_last=1.
- Backpressure: out_ready toggles 1,0,0,1,... during an all-enabled vector -> data/idx/last stable across every stalled cycle; no beat dropped or duplicated; 16 transfers total.
- Empty mask, lane_en = 0, load=1 -> single beat data 0, idx 0, last=1 at t+1; busy=0 two cycles after the transfer.
- load pulsed while busy with different lanes -> ignored; original vector completes, then a second load in the following IDLE cycle streams the new vector.
- rst asserted low mid-stream after beat idx 5 -> busy, out_valid, out_data, out_idx, out_last go 0 immediately (no clock needed); after release, no further beats until a new load.
